// File: rtl/coord_slew_limiter.sv
// Per-axis slew limiter: each tick moves X/Y/Z toward the captured target by at most MAX_STEP, publishing 5 cycles after the tick.
// Optional macro SLEW_DEADBAND_EN: deltas within +/-DEADBAND are ignored and count as settled.
module coord_slew_limiter #(
  parameter int BIT_SIZE    = 10,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int UPDATE_FREQ = 100,
  parameter int MAX_STEP    = 8,
  parameter int DEADBAND    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [BIT_SIZE-1:0] x_in,
  input  logic signed [BIT_SIZE-1:0] y_in,
  input  logic signed [BIT_SIZE-1:0] z_in,
  input  logic                       hold,
  output logic signed [BIT_SIZE-1:0] x_out,
  output logic signed [BIT_SIZE-1:0] y_out,
  output logic signed [BIT_SIZE-1:0] z_out,
  output logic                       out_valid,
  output logic                       moving
);

  localparam int DIV = CLK_FREQ / UPDATE_FREQ;
  localparam int CW  = $clog2(DIV);
  localparam int DW  = BIT_SIZE + 1;
  localparam logic [CW-1:0]        DIV_M1     = CW'(DIV - 1);
  localparam logic signed [DW-1:0] MAX_STEP_W = DW'(MAX_STEP);
`ifdef SLEW_DEADBAND_EN
  localparam logic signed [DW-1:0] DEADBAND_W = DW'(DEADBAND);
`endif

  generate
    if (DIV < 8) begin : g_div_chk
      $error("coord_slew_limiter: CLK_FREQ/UPDATE_FREQ must be >= 8");
    end
    if (MAX_STEP < 1 || MAX_STEP > (2 ** (BIT_SIZE - 1)) - 1) begin : g_step_chk
      $error("coord_slew_limiter: MAX_STEP out of range");
    end
    if (DEADBAND < 0) begin : g_db_chk
      $error("coord_slew_limiter: DEADBAND must be non-negative");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_STEP_X, S_STEP_Y, S_STEP_Z, S_PUBLISH
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic signed [BIT_SIZE-1:0] cx_q, cy_q, cz_q;
  logic signed [BIT_SIZE-1:0] tx_q, ty_q, tz_q;
  logic signed [BIT_SIZE-1:0] x_out_q, y_out_q, z_out_q;
  logic                       out_valid_q, moving_q;
  logic signed [BIT_SIZE-1:0] cur_sel, tgt_sel, step_res;
  logic                       moving_d;

  // Difference is formed one bit wider so extreme targets cannot overflow.
  function automatic logic signed [DW-1:0] axis_diff(
    input logic signed [BIT_SIZE-1:0] cur,
    input logic signed [BIT_SIZE-1:0] tgt
  );
    axis_diff = $signed({tgt[BIT_SIZE-1], tgt}) - $signed({cur[BIT_SIZE-1], cur});
  endfunction

  function automatic logic signed [DW-1:0] abs_w(input logic signed [DW-1:0] d);
    abs_w = (d < 0) ? -d : d;
  endfunction

  function automatic logic axis_settled(
    input logic signed [BIT_SIZE-1:0] cur,
    input logic signed [BIT_SIZE-1:0] tgt
  );
`ifdef SLEW_DEADBAND_EN
    axis_settled = (abs_w(axis_diff(cur, tgt)) <= DEADBAND_W);
`else
    axis_settled = (cur == tgt);
`endif
  endfunction

  function automatic logic signed [BIT_SIZE-1:0] axis_step(
    input logic signed [BIT_SIZE-1:0] cur,
    input logic signed [BIT_SIZE-1:0] tgt
  );
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] mag;
    logic signed [DW-1:0] nxt;
    d   = axis_diff(cur, tgt);
    mag = abs_w(d);
    if (axis_settled(cur, tgt)) begin
      nxt = {cur[BIT_SIZE-1], cur};
    end else if (mag <= MAX_STEP_W) begin
      nxt = {tgt[BIT_SIZE-1], tgt};
    end else if (d < 0) begin
      nxt = $signed({cur[BIT_SIZE-1], cur}) - MAX_STEP_W;
    end else begin
      nxt = $signed({cur[BIT_SIZE-1], cur}) + MAX_STEP_W;
    end
    axis_step = nxt[BIT_SIZE-1:0];
  endfunction

  assign tick = (cnt_q == DIV_M1);

  // One shared step datapath, steered by the current STEP_* state.
  always_comb begin
    cur_sel = cx_q;
    tgt_sel = tx_q;
    case (state_q)
      S_STEP_Y: begin cur_sel = cy_q; tgt_sel = ty_q; end
      S_STEP_Z: begin cur_sel = cz_q; tgt_sel = tz_q; end
      default:  begin cur_sel = cx_q; tgt_sel = tx_q; end
    endcase
    step_res = axis_step(cur_sel, tgt_sel);
  end

  assign moving_d = !axis_settled(cx_q, tx_q) || !axis_settled(cy_q, ty_q) ||
                    !axis_settled(cz_q, tz_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tick && !hold) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_STEP_X;
      S_STEP_X:  state_d = S_STEP_Y;
      S_STEP_Y:  state_d = S_STEP_Z;
      S_STEP_Z:  state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      cz_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      tz_q        <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      out_valid_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= tick ? '0 : cnt_q + CW'(1);
      out_valid_q <= (state_q == S_PUBLISH);
      case (state_q)
        S_CAPTURE: begin
          tx_q <= x_in;
          ty_q <= y_in;
          tz_q <= z_in;
        end
        S_STEP_X: cx_q <= step_res;
        S_STEP_Y: cy_q <= step_res;
        S_STEP_Z: cz_q <= step_res;
        S_PUBLISH: begin
          x_out_q  <= cx_q;
          y_out_q  <= cy_q;
          z_out_q  <= cz_q;
          moving_q <= moving_d;
        end
        default: ;
      endcase
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign out_valid = out_valid_q;
  assign moving    = moving_q;

endmodule

// File: doc/coord_slew_limiter.md
# coord_slew_limiter

Rate-limits the selected X/Y/Z coordinate stream, either memory or accelerometer, before it reaches `pwm_servos`. Each axis moves toward its target by at most `MAX_STEP` counts per update tick. This prevents servo jumps when `select_source` toggles, a ROM entry loads, or the accelerometer spikes. It sits between the source multiplexer and `pwm_servos`/`vga`, and emits a one-cycle `out_valid` strobe on every published update.

## Interface
- `BIT_SIZE`, 10: coordinate width, two's complement signed.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `UPDATE_FREQ`, 100: update tick rate in Hz. `DIV = CLK_FREQ/UPDATE_FREQ` must be ≥ 8 (elaboration error otherwise).
- `MAX_STEP`, 8: maximum per-tick change per axis, 1..2^(BIT_SIZE-1)-1.
- `DEADBAND`, 2: dead-zone half-width. Used only with `SLEW_DEADBAND_EN`.
- `clk`  in  1  system clock (MAX10_CLK1_50).
- `rst`  in  1  one clock; reset is synchronous and active-high (sampled on rising `clk`).
- `x_in`, `y_in`, `z_in`  in  BIT_SIZE each  target coordinates (from mux).
- `hold`  in  1  freeze outputs; sampled on the tick cycle.
- `x_out`, `y_out`, `z_out`  out  BIT_SIZE each  slewed coordinates, registered.
- `out_valid`  out  1  one-cycle pulse when outputs update.
- `moving`  out  1  high while any published axis differs from its last captured target.

## Operation
- Tick counter counts 0..DIV-1 and wraps. `tick` = (count == DIV-1).
- FSM states:
  - IDLE: on `tick`, go to CAPTURE if `hold`=0, else stay in IDLE (no pulse).
  - CAPTURE: latch `x_in`/`y_in`/`z_in` into target registers tx/ty/tz.
  - STEP_X, STEP_Y, STEP_Z: one axis per cycle on a shared datapath.
  - PUBLISH: go to IDLE.
- Per axis step, with cur = working register, t = target:
  - d = t − cur, computed sign-extended to BIT_SIZE+1 bits, so no overflow.
  - If |d| ≤ MAX_STEP: cur ← t.
  - Else: cur ← cur + MAX_STEP·sign(d).
  - Intermediate results never leave [−2^(BIT_SIZE-1), 2^(BIT_SIZE-1)−1]. No wrap-around is possible.
- PUBLISH:
  - Working registers are copied to `x_out`/`y_out`/`z_out`.
  - `out_valid`=1 for that cycle only.
  - `moving` ← OR over axes of (new cur ≠ t).
- Inputs change freely between ticks. Only values present on the CAPTURE cycle matter.
- `hold`=1 while the FSM is mid-sequence has no effect until the next tick.
- Reset:
  - All outputs, working and target registers, and the tick counter go to 0.
  - `out_valid`=0, `moving`=0, state IDLE.
  - Reset mid-sequence aborts the sequence with no `out_valid`. The counter restarts, so the first tick occurs DIV cycles after `rst` deasserts.

## Timing
- `tick` at cycle T → CAPTURE at T+1 → STEP_X/Y/Z at T+2..T+4 → PUBLISH at T+5.
- Outputs and `out_valid` are visible after the T+5 edge. Latency is 5 cycles from tick.
- Update period is exactly DIV cycles. A sequence always finishes before the next tick.
- Full traversal from −512 to +511 with MAX_STEP=8 takes ceil(1023/8)=128 ticks.

## Configuration
- `SLEW_DEADBAND_EN` defined:
  - In the step rule, an axis with |d| ≤ DEADBAND is left unchanged (cur holds).
  - `moving` ignores such axes (they count as settled).
  - This suppresses accelerometer jitter.
- `SLEW_DEADBAND_EN` undefined:
  - Any nonzero d moves the axis.
  - The `DEADBAND` parameter is unused.

## Test plan
Use CLK_FREQ=1000, UPDATE_FREQ=100 (DIV=10), MAX_STEP=8.
1. Reset, then x_in=20, y_in=−20, z_in=3 held.
   - Tick 1: out = (8, −8, 3), moving=1.
   - Tick 2: out = (16, −16, 3).
   - Tick 3: out = (20, −20, 3), moving=0.
   - `out_valid` pulses exactly once per tick, 5 cycles after each tick.
2. Extremes: x from 511 to −512.
   - Decreases 8 per tick, no wrap.
   - Reaches −512 on tick 128 (last step 7).
3. `hold`=1 at a tick: no `out_valid`, outputs unchanged. Release: the next tick resumes stepping.
4. Input changes on a non-CAPTURE cycle, then reverts before the next tick: outputs are unaffected.
5. `rst` asserted at T+3 mid-sequence: no pulse, all outputs 0. The next tick lands 10 cycles after `rst` falls.
6. Deadband with `SLEW_DEADBAND_EN`, DEADBAND=2, outputs settled at 0, x_in=2:
   - With the macro: x_out stays 0 and moving=0.
   - Without the macro: x_out=2.
